// File: rtl/pp_mode_pkg.sv
// Postprocessor mode definitions shared by the scheduler and the postprocessor.
// Holds the state codes, the scheduler FSM encoding, the enable bundle and
// the code -> enable decode / code validity helpers.
package pp_mode_pkg;

  localparam int unsigned PP_CODE_W = 5;

  localparam logic [PP_CODE_W-1:0] PP_PASSTHRU   = 5'd0;
  localparam logic [PP_CODE_W-1:0] PP_GRAY       = 5'd1;
  localparam logic [PP_CODE_W-1:0] PP_TEMPORAL   = 5'd2;
  localparam logic [PP_CODE_W-1:0] PP_TRACK      = 5'd3;
  localparam logic [PP_CODE_W-1:0] PP_TRACK_BBOX = 5'd4;
  localparam logic [PP_CODE_W-1:0] PP_SPLIT      = 5'd5;
  localparam logic [PP_CODE_W-1:0] PP_PONG       = 5'd21;

  typedef enum logic [1:0] {SCH_IDLE, SCH_PENDING, SCH_COMMIT} sch_state_e;

  // Enable strobes implied by a committed mode.
  typedef struct packed {
    logic processing;
    logic temporal;
    logic overlay;
    logic bbox;
    logic split;
    logic gesture;
  } pp_ctrl_t;

  // Mode code to enable bundle; unknown codes decode to all-off.
  function automatic pp_ctrl_t pp_decode(input logic [PP_CODE_W-1:0] code);
    pp_ctrl_t c;
    c = '0;
    case (code)
      PP_GRAY:       c.processing = 1'b1;
      PP_TEMPORAL:   begin c.processing = 1'b1; c.temporal = 1'b1; end
      PP_TRACK:      begin c.processing = 1'b1; c.overlay = 1'b1; c.gesture = 1'b1; end
      PP_TRACK_BBOX: begin
        c.processing = 1'b1; c.overlay = 1'b1; c.bbox = 1'b1; c.gesture = 1'b1;
      end
      PP_SPLIT:      begin
        c.processing = 1'b1; c.overlay = 1'b1; c.bbox = 1'b1; c.split = 1'b1;
      end
      PP_PONG:       begin c.processing = 1'b1; c.split = 1'b1; end
      default:       c = '0;
    endcase
    return c;
  endfunction

  // True only for the seven defined mode codes.
  function automatic logic pp_valid(input logic [PP_CODE_W-1:0] code);
    logic v;
    v = 1'b0;
    case (code)
      PP_PASSTHRU, PP_GRAY, PP_TEMPORAL, PP_TRACK,
      PP_TRACK_BBOX, PP_SPLIT, PP_PONG: v = 1'b1;
      default:                          v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/frame_start_detect.sv
// One-cycle pulse on the first cycle the raster position reads (0,0).
// Ports: clk, rst_n; draw_x_i/draw_y_i raster position;
// frame_start_c_o combinational pulse (edge of the (0,0) decode).
// The history flop resets to 1 so no pulse appears right after reset.
module frame_start_detect #(
  parameter int unsigned XY_W        = 10,
  parameter int unsigned FRAME_WIDTH = 640
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XY_W-1:0] draw_x_i,
  input  logic [XY_W-1:0] draw_y_i,
  output logic            frame_start_c_o
);

  localparam logic [XY_W:0] FW_C = (XY_W+1)'(FRAME_WIDTH);

  logic fs_raw_c;
  logic fs_raw_q;

  assign fs_raw_c        = (draw_x_i == '0) && (draw_y_i == '0);
  assign frame_start_c_o = fs_raw_c && !fs_raw_q;

  // Previous-cycle copy of the (0,0) decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fs_raw_q <= 1'b1;
    else        fs_raw_q <= fs_raw_c;
  end

  // The x coordinate never leaves the active line.
  a_x_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    {1'b0, draw_x_i} < FW_C);

endmodule

// File: rtl/postproc_mode_scheduler.sv
// Owns the postprocessor control word. Arbitrates user and gesture mode
// requests (user wins), stages the accepted code and commits it only at a
// frame boundary; gesture commits start a frame-counted hold-off.
// Ports: clk, rst_n; draw_x/draw_y raster position; usr_*/ges_* request,
// code and one-cycle ack; current_state and six decoded enables; pending,
// commit_pulse and holdoff_active status. All outputs are registered.
module postproc_mode_scheduler
  import pp_mode_pkg::*;
#(
  parameter logic [4:0]  DEFAULT_STATE  = 5'd0,
  parameter int unsigned HOLDOFF_FRAMES = 30,
  parameter int unsigned FRAME_WIDTH    = 640
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic       usr_req,
  input  logic [4:0] usr_state,
  output logic       usr_ack,
  input  logic       ges_req,
  input  logic [4:0] ges_state,
  output logic       ges_ack,
  output logic [4:0] current_state,
  output logic       processing_enable,
  output logic       temporal_filter_enable,
  output logic       overlay_enable,
  output logic       bbox_overlay_enable,
  output logic       split_centroid_enable,
  output logic       gesture_enable,
  output logic       pending,
  output logic       commit_pulse,
  output logic       holdoff_active
);

  localparam int unsigned XY_W   = 10;
  localparam int unsigned HOLD_W = 8;

  logic frame_start_c;

  frame_start_detect #(
    .XY_W        (XY_W),
    .FRAME_WIDTH (FRAME_WIDTH)
  ) u_fs (
    .clk             (clk),
    .rst_n           (rst_n),
    .draw_x_i        (draw_x),
    .draw_y_i        (draw_y),
    .frame_start_c_o (frame_start_c)
  );

  sch_state_e              state_q, state_d;
  logic [PP_CODE_W-1:0]    staged_q, staged_d;
  logic                    src_ges_q, src_ges_d;
  logic [HOLD_W-1:0]       holdoff_q, holdoff_d;
  logic [PP_CODE_W-1:0]    cur_q, cur_d;
  pp_ctrl_t                ctrl_q, ctrl_d;
  logic                    usr_ack_q, usr_ack_d;
  logic                    ges_ack_q, ges_ack_d;
  logic                    pending_q, pending_d;
  logic                    commit_q, commit_d;
  logic                    hold_act_q, hold_act_d;
  logic                    usr_take_c, ges_take_c;

  // A request still high during its own ack cycle is the one just taken.
  assign usr_take_c = usr_req && !usr_ack_q;
  assign ges_take_c = ges_req && !ges_ack_q && (holdoff_q == '0);

  // Next-state, staging, commit and hold-off logic.
  always_comb begin
    state_d    = state_q;
    staged_d   = staged_q;
    src_ges_d  = src_ges_q;
    holdoff_d  = holdoff_q;
    cur_d      = cur_q;
    ctrl_d     = ctrl_q;
    usr_ack_d  = 1'b0;
    ges_ack_d  = 1'b0;
    commit_d   = 1'b0;

    if (frame_start_c && (holdoff_q != '0)) holdoff_d = holdoff_q - HOLD_W'(1);

    case (state_q)
      SCH_IDLE: begin
        if (usr_take_c) begin
          usr_ack_d = 1'b1;
          if (pp_valid(usr_state)) begin
            staged_d  = usr_state;
            src_ges_d = 1'b0;
            state_d   = SCH_PENDING;
          end
        end else if (ges_take_c) begin
          ges_ack_d = 1'b1;
          if (pp_valid(ges_state)) begin
            staged_d  = ges_state;
            src_ges_d = 1'b1;
            state_d   = SCH_PENDING;
          end
        end
      end
      SCH_PENDING: begin
        if (usr_take_c) begin
          usr_ack_d = 1'b1;
          if (pp_valid(usr_state)) begin
            staged_d  = usr_state;
            src_ges_d = 1'b0;
          end
        end
        // Load the outputs on the boundary so they are visible in COMMIT.
        if (frame_start_c) begin
          state_d  = SCH_COMMIT;
          cur_d    = staged_d;
          ctrl_d   = pp_decode(staged_d);
          commit_d = 1'b1;
        end
      end
      SCH_COMMIT: begin
        if (src_ges_q) holdoff_d = HOLD_W'(HOLDOFF_FRAMES);
        state_d = SCH_IDLE;
      end
      default: state_d = SCH_IDLE;
    endcase

    pending_d  = (state_d == SCH_PENDING);
    hold_act_d = (holdoff_d != '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCH_IDLE;
      staged_q   <= DEFAULT_STATE;
      src_ges_q  <= 1'b0;
      holdoff_q  <= '0;
      cur_q      <= DEFAULT_STATE;
      ctrl_q     <= pp_decode(DEFAULT_STATE);
      usr_ack_q  <= 1'b0;
      ges_ack_q  <= 1'b0;
      pending_q  <= 1'b0;
      commit_q   <= 1'b0;
      hold_act_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      staged_q   <= staged_d;
      src_ges_q  <= src_ges_d;
      holdoff_q  <= holdoff_d;
      cur_q      <= cur_d;
      ctrl_q     <= ctrl_d;
      usr_ack_q  <= usr_ack_d;
      ges_ack_q  <= ges_ack_d;
      pending_q  <= pending_d;
      commit_q   <= commit_d;
      hold_act_q <= hold_act_d;
    end
  end

  assign usr_ack                = usr_ack_q;
  assign ges_ack                = ges_ack_q;
  assign current_state          = cur_q;
  assign processing_enable      = ctrl_q.processing;
  assign temporal_filter_enable = ctrl_q.temporal;
  assign overlay_enable         = ctrl_q.overlay;
  assign bbox_overlay_enable    = ctrl_q.bbox;
  assign split_centroid_enable  = ctrl_q.split;
  assign gesture_enable         = ctrl_q.gesture;
  assign pending                = pending_q;
  assign commit_pulse           = commit_q;
  assign holdoff_active         = hold_act_q;

endmodule

// File: tb/tb_postproc_mode_scheduler.sv
// Directed bench for postproc_mode_scheduler (hold-off of 3 frames).
// Frames are modelled by parking the raster at (1,0) and dropping it to
// (0,0) for a single cycle.
module tb_postproc_mode_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] draw_x, draw_y;
  logic       usr_req, ges_req;
  logic [4:0] usr_state, ges_state;
  logic       usr_ack, ges_ack;
  logic [4:0] current_state;
  logic       processing_enable, temporal_filter_enable, overlay_enable;
  logic       bbox_overlay_enable, split_centroid_enable, gesture_enable;
  logic       pending, commit_pulse, holdoff_active;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  postproc_mode_scheduler #(
    .DEFAULT_STATE  (5'd0),
    .HOLDOFF_FRAMES (3),
    .FRAME_WIDTH    (640)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .draw_x                 (draw_x),
    .draw_y                 (draw_y),
    .usr_req                (usr_req),
    .usr_state              (usr_state),
    .usr_ack                (usr_ack),
    .ges_req                (ges_req),
    .ges_state              (ges_state),
    .ges_ack                (ges_ack),
    .current_state          (current_state),
    .processing_enable      (processing_enable),
    .temporal_filter_enable (temporal_filter_enable),
    .overlay_enable         (overlay_enable),
    .bbox_overlay_enable    (bbox_overlay_enable),
    .split_centroid_enable  (split_centroid_enable),
    .gesture_enable         (gesture_enable),
    .pending                (pending),
    .commit_pulse           (commit_pulse),
    .holdoff_active         (holdoff_active)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    draw_x = 10'd0;
    draw_y = 10'd0;
    step();
    draw_x = 10'd1;
    draw_y = 10'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bits ordered {proc, temporal, overlay, bbox, split, gesture}.
  task automatic chk_en(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, processing_enable, temporal_filter_enable, overlay_enable,
              bbox_overlay_enable, split_centroid_enable, gesture_enable},
        {26'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; usr_req = 1'b0; ges_req = 1'b0;
    usr_state = 5'd0; ges_state = 5'd0;
    draw_x = 10'd1; draw_y = 10'd0;
    step(); step(); step();
    chk("rst_state", 32'(current_state), 32'd0);
    chk_en("rst_en", 6'b000000);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_commit", 32'(commit_pulse), 32'd0);
    chk("rst_acks", {30'd0, usr_ack, ges_ack}, 32'd0);
    chk("rst_hold", 32'(holdoff_active), 32'd0);
    rst_n = 1'b1;
    step();

    // Two idle frames
    for (int f = 0; f < 2; f++) begin
      frame_pulse();
      chk("idle_commit", 32'(commit_pulse), 32'd0);
      step();
    end
    chk("idle_state", 32'(current_state), 32'd0);

    // User request TRACK_BBOX mid-frame
    usr_req = 1'b1; usr_state = 5'd4;
    step();
    chk("u4_ack", 32'(usr_ack), 32'd1);
    chk("u4_pend", 32'(pending), 32'd1);
    chk("u4_state_held", 32'(current_state), 32'd0);
    usr_req = 1'b0;
    step();
    chk("u4_ack_once", 32'(usr_ack), 32'd0);
    frame_pulse();
    chk("u4_state", 32'(current_state), 32'd4);
    chk("u4_commit", 32'(commit_pulse), 32'd1);
    chk_en("u4_en", 6'b101101);
    step();
    chk("u4_commit_end", 32'(commit_pulse), 32'd0);
    chk("u4_pend_end", 32'(pending), 32'd0);

    // Simultaneous user 3 / gesture 5
    usr_req = 1'b1; usr_state = 5'd3;
    ges_req = 1'b1; ges_state = 5'd5;
    step();
    chk("sim_uack", 32'(usr_ack), 32'd1);
    chk("sim_gack", 32'(ges_ack), 32'd0);
    usr_req = 1'b0;
    step();
    chk("sim_gack_pend", 32'(ges_ack), 32'd0);
    frame_pulse();
    chk("sim_state3", 32'(current_state), 32'd3);
    chk_en("sim_en3", 6'b101001);
    step();
    chk("sim_gack_commit", 32'(ges_ack), 32'd0);
    step();
    chk("sim_gack_idle", 32'(ges_ack), 32'd1);
    chk("sim_gpend", 32'(pending), 32'd1);
    ges_req = 1'b0;
    step();
    frame_pulse();
    chk("sim_state5", 32'(current_state), 32'd5);
    chk("sim_commit5", 32'(commit_pulse), 32'd1);
    chk_en("sim_en5", 6'b101110);
    step();
    chk("sim_hold", 32'(holdoff_active), 32'd1);

    // Drain hold-off: 3 -> 2 -> 1 -> 0
    frame_pulse(); chk("drain1", 32'(holdoff_active), 32'd1); step();
    frame_pulse(); chk("drain2", 32'(holdoff_active), 32'd1); step();
    frame_pulse(); chk("drain3", 32'(holdoff_active), 32'd0); step();

    // Gesture commit to TEMPORAL, then a held gesture request
    ges_req = 1'b1; ges_state = 5'd2;
    step();
    chk("g2_ack", 32'(ges_ack), 32'd1);
    ges_req = 1'b0;
    step();
    frame_pulse();
    chk("g2_state", 32'(current_state), 32'd2);
    chk_en("g2_en", 6'b110000);
    step();
    chk("g2_hold", 32'(holdoff_active), 32'd1);
    ges_req = 1'b1; ges_state = 5'd1;
    step();
    chk("ho_noack0", 32'(ges_ack), 32'd0);
    frame_pulse();
    chk("ho_noack1", 32'(ges_ack), 32'd0);
    usr_req = 1'b1; usr_state = 5'd0;
    step();
    chk("ho_uack", 32'(usr_ack), 32'd1);
    usr_req = 1'b0;
    step();
    frame_pulse();
    chk("ho_ustate", 32'(current_state), 32'd0);
    chk("ho_ucommit", 32'(commit_pulse), 32'd1);
    chk("ho_hold_kept", 32'(holdoff_active), 32'd1);
    step();
    chk("ho_hold_noreload", 32'(holdoff_active), 32'd1);
    step();
    chk("ho_noack2", 32'(ges_ack), 32'd0);
    frame_pulse();
    chk("ho_hold_zero", 32'(holdoff_active), 32'd0);
    chk("ho_noack3", 32'(ges_ack), 32'd0);
    step();
    chk("ho_gack", 32'(ges_ack), 32'd1);
    ges_req = 1'b0;
    step();
    frame_pulse();
    chk("ho_gstate", 32'(current_state), 32'd1);
    chk_en("ho_gen", 6'b100000);
    step();
    chk("ho_reload", 32'(holdoff_active), 32'd1);

    // Invalid code in IDLE, held one extra cycle
    usr_req = 1'b1; usr_state = 5'd9;
    step();
    chk("inv_ack", 32'(usr_ack), 32'd1);
    chk("inv_pend", 32'(pending), 32'd0);
    step();
    chk("inv_ack_once", 32'(usr_ack), 32'd0);
    usr_req = 1'b0;
    frame_pulse();
    chk("inv_commit", 32'(commit_pulse), 32'd0);
    chk("inv_state", 32'(current_state), 32'd1);
    step();

    // PONG staged, then invalid overwrite attempt
    usr_req = 1'b1; usr_state = 5'd21;
    step();
    chk("pong_ack", 32'(usr_ack), 32'd1);
    usr_req = 1'b0;
    step();
    usr_req = 1'b1; usr_state = 5'd9;
    step();
    chk("pinv_ack", 32'(usr_ack), 32'd1);
    chk("pinv_pend", 32'(pending), 32'd1);
    usr_req = 1'b0;
    step();
    frame_pulse();
    chk("pong_state", 32'(current_state), 32'd21);
    chk_en("pong_en", 6'b100010);
    step();

    // Reset while PENDING with SPLIT staged
    usr_req = 1'b1; usr_state = 5'd5;
    step();
    chk("rp_pend", 32'(pending), 32'd1);
    usr_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rp_state", 32'(current_state), 32'd0);
    chk_en("rp_en", 6'b000000);
    chk("rp_pend0", 32'(pending), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    frame_pulse();
    chk("rp_nocommit", 32'(commit_pulse), 32'd0);
    chk("rp_state2", 32'(current_state), 32'd0);
    step();

    // Accept coinciding with frame start commits one frame later
    usr_req = 1'b1; usr_state = 5'd1;
    draw_x = 10'd0; draw_y = 10'd0;
    step();
    draw_x = 10'd1;
    usr_req = 1'b0;
    chk("fsa_pend", 32'(pending), 32'd1);
    step();
    chk("fsa_nocommit", 32'(commit_pulse), 32'd0);
    frame_pulse();
    chk("fsa_state", 32'(current_state), 32'd1);
    chk("fsa_commit", 32'(commit_pulse), 32'd1);
    step();

    // Re-commit of the current code still pulses
    usr_req = 1'b1; usr_state = 5'd1;
    step();
    usr_req = 1'b0;
    step();
    frame_pulse();
    chk("same_commit", 32'(commit_pulse), 32'd1);
    chk("same_state", 32'(current_state), 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
